// File: rtl/axi_full_slave_mem.sv
// AXI4-Full slave backed by a word-addressed on-chip memory.
// Independent single-burst read and write FSMs; INCR and FIXED bursts, byte strobes.
module axi_full_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH_WORDS    = 1024
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  w_state_e                  w_state_q, w_state_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [IDX_W-1:0]          w_idx_q, w_idx_d;
  logic [7:0]                w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                      w_fixed_q, w_fixed_d, w_bad_q, w_bad_d, w_err_q, w_err_d;
  logic                      w_in_range_c, w_last_beat_c, mem_we_c;

  r_state_e                  r_state_q, r_state_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]          r_idx_q, r_idx_d, rd_idx_c;
  logic [7:0]                r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                      r_fixed_q, r_fixed_d, r_bad_q, r_bad_d;
  logic                      rd_load_c, rd_bad_c, rd_ok_c;
  logic                      unused_c;

  assign unused_c = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write channel: accept AW, consume LEN+1 beats by count, then respond
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_fixed_d = w_fixed_q;
    w_bad_d   = w_bad_q;
    w_err_d   = w_err_q;
    mem_we_c  = 1'b0;
    w_in_range_c  = w_idx_q < IDX_W'(MEM_DEPTH_WORDS);
    w_last_beat_c = w_beat_q == w_len_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
          bid_d     = S_AXI_AWID;
          w_idx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
          w_len_d   = S_AXI_AWLEN;
          w_beat_d  = 8'd0;
          w_fixed_d = S_AXI_AWBURST == 2'b00;
          w_bad_d   = S_AXI_AWBURST[1] || (S_AXI_AWSIZE != 3'(ADDR_LSB));
          w_err_d   = w_bad_d;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we_c = !w_bad_q && w_in_range_c;
          w_err_d  = w_err_q || !w_in_range_c || (S_AXI_WLAST != w_last_beat_c);
          w_idx_d  = w_fixed_q ? w_idx_q : w_idx_q + IDX_W'(1);
          w_beat_d = w_beat_q + 8'd1;
          if (w_last_beat_c) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_fixed_q <= 1'b0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_fixed_q <= w_fixed_d;
      w_bad_q   <= w_bad_d;
      w_err_q   <= w_err_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_q[MEM_AW-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // Read channel: prefetch the next beat into the output register on each handshake
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_fixed_d = r_fixed_q;
    r_bad_d   = r_bad_q;
    rd_idx_c  = r_idx_q;
    rd_bad_c  = r_bad_q;
    rd_load_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          rid_d     = S_AXI_ARID;
          rd_idx_c  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
          rd_bad_c  = S_AXI_ARBURST[1] || (S_AXI_ARSIZE != 3'(ADDR_LSB));
          r_bad_d   = rd_bad_c;
          r_len_d   = S_AXI_ARLEN;
          r_beat_d  = 8'd0;
          r_fixed_d = S_AXI_ARBURST == 2'b00;
          rlast_d   = S_AXI_ARLEN == 8'd0;
          rd_load_c = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rd_idx_c  = r_fixed_q ? r_idx_q : r_idx_q + IDX_W'(1);
            r_beat_d  = r_beat_q + 8'd1;
            rlast_d   = r_beat_d == r_len_q;
            rd_load_c = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_idx_d = rd_idx_c;
    rd_ok_c = !rd_bad_c && (rd_idx_c < IDX_W'(MEM_DEPTH_WORDS));
    if (rd_load_c) begin
      rdata_d = rd_ok_c ? mem[rd_idx_c[MEM_AW-1:0]] : '0;
      rresp_d = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_fixed_q <= 1'b0;
      r_bad_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_fixed_q <= r_fixed_d;
      r_bad_q   <= r_bad_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Directed plus randomized bench for axi_full_slave_mem against an array-based memory model.
module tb_axi_full_slave_mem;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n = 1'b1;
  logic [0:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];

  axi_full_slave_mem #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write burst; the model applies the spec's per-beat rules afterwards
  task automatic axi_write(input logic [0:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at);
    int n;
    int idx;
    logic bad, err;
    logic [1:0] resp_o;
    logic [0:0] bid_o;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin tick(); n++; end
    chk("aw_accept", 64'(n < 100), 64'd1);
    tick();
    awvalid = 1'b0;
    chk("wready_after_aw", 64'(wready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == last_at);
      n = 0;
      while (!wready && n < 100) begin tick(); n++; end
      chk("w_accept", 64'(n < 100), 64'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_w", 64'(bvalid), 64'd1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin tick(); n++; end
    resp_o = bresp; bid_o = bid;
    tick();
    bready = 1'b0;
    chk("awready_rearm", 64'(awready), 64'd1);
    bad = burst[1] || (size != 3'd2);
    err = bad || (last_at != len);
    for (int i = 0; i <= len; i++) begin
      idx = int'(addr >> 2) + ((burst == 2'b01) ? i : 0);
      if (idx >= DEPTH) err = 1'b1;
      else if (!bad)
        for (int b = 0; b < 4; b++) if (wstb[i][b]) model[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
    end
    chk("bresp", 64'(resp_o), err ? 64'd2 : 64'd0);
    chk("bid", 64'(bid_o), 64'(id));
  endtask

  // One read burst; mode 0 = RREADY high, 1 = pattern 1,0,0,1, 2 = random
  task automatic axi_read(input logic [0:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
    int n, beat, cyc, idx;
    logic ok, rr;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin tick(); n++; end
    chk("ar_accept", 64'(n < 100), 64'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_after_ar", 64'(rvalid), 64'd1);
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      rready = rr;
      if (mode == 0) chk("r_no_bubble", 64'(rvalid), 64'd1);
      if (rvalid) begin
        idx = int'(addr >> 2) + ((burst == 2'b01) ? beat : 0);
        ok  = !burst[1] && (size == 3'd2) && (idx < DEPTH);
        chk("rdata", 64'(rdata), ok ? 64'(model[idx]) : 64'd0);
        chk("rresp", 64'(rresp), ok ? 64'd0 : 64'd2);
        chk("rlast", 64'(rlast), 64'(beat == len));
        chk("rid", 64'(rid), 64'(id));
        if (rr) beat++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("r_beat_count", 64'(beat), 64'(len + 1));
    chk("rvalid_done", 64'(rvalid), 64'd0);
    chk("arready_rearm", 64'(arready), 64'd1);
  endtask

  initial begin
    logic [1:0] rb, wb;
    int r, wlen, rlen, wlast_at;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_r_fields", 64'({rlast, rdata, rresp, rid}), 64'd0);
    chk("rst_b_fields", 64'({bresp, bid}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);

    // Fill the whole memory so every model word is known
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      axi_write(1'b0, 32'(k * 1024), 255, 2'b01, 3'd2, 255);
    end

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'h11 * 32'(i + 1); wstb[i] = 4'hF; end
    axi_write(1'b1, 32'h40, 3, 2'b01, 3'd2, 3);
    axi_read(1'b1, 32'h40, 3, 2'b01, 3'd2, 0);

    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
    axi_write(1'b0, 32'h0, 0, 2'b01, 3'd2, 0);
    wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
    axi_write(1'b0, 32'h0, 0, 2'b01, 3'd2, 0);
    chk("strobe_merge_model", 64'(model[0]), 64'h00000000AA22CC44);
    axi_read(1'b0, 32'h0, 0, 2'b01, 3'd2, 0);

    axi_read(1'b1, 32'h100, 7, 2'b01, 3'd2, 1);

    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    axi_write(1'b1, 32'((DEPTH - 2) * 4), 3, 2'b01, 3'd2, 3);
    axi_read(1'b1, 32'((DEPTH - 2) * 4), 3, 2'b01, 3'd2, 0);

    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    axi_write(1'b0, 32'h200, 3, 2'b10, 3'd2, 3);
    axi_read(1'b0, 32'h200, 3, 2'b01, 3'd2, 0);
    axi_write(1'b1, 32'h300, 3, 2'b01, 3'd2, 1);
    axi_write(1'b0, 32'h300, 3, 2'b00, 3'd2, 3);
    axi_read(1'b0, 32'h300, 3, 2'b01, 3'd2, 0);
    axi_read(1'b1, 32'h300, 2, 2'b00, 3'd2, 2);

    // Random bursts; odd iterations run write and read concurrently on disjoint words
    for (int it = 0; it < 20; it++) begin
      r = int'($urandom_range(0, 9));
      wb = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      r = int'($urandom_range(0, 9));
      rb = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      wlen = int'($urandom_range(0, 15));
      rlen = int'($urandom_range(0, 15));
      wlast_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : wlen;
      for (int i = 0; i <= wlen; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      if (it % 2 == 0) begin
        axi_write(1'($urandom), 32'($urandom_range(0, 1100) * 4 + $urandom_range(0, 3)), wlen, wb,
                  ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2, wlast_at);
        axi_read(1'($urandom), 32'($urandom_range(0, 1100) * 4 + $urandom_range(0, 3)), rlen, rb,
                 ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2, int'($urandom_range(0, 2)));
      end else begin
        fork
          axi_write(1'b1, 32'($urandom_range(0, 480) * 4), wlen, wb, 3'd2, wlast_at);
          axi_read(1'b0, 32'($urandom_range(560, 1100) * 4), rlen, rb, 3'd2, int'($urandom_range(0, 2)));
        join
      end
    end

    // Reset while beat 2 of an 8-beat read is on the bus
    arid = 1'b1; araddr = 32'h80; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    tick(); tick();
    chk("mid_read_rvalid", 64'(rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rvalid_clear", 64'(rvalid), 64'd0);
    chk("async_arready_clear", 64'(arready), 64'd0);
    rready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rearm_after_reset", 64'(arready), 64'd1);
    axi_read(1'b0, 32'h80, 7, 2'b01, 3'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_full_slave_mem.md
# axi_full_slave_mem

AXI4-Full slave with an internal word-addressed memory. It is the responder on the far end of the engine's AXI4-Full master DMA (read and write paths), and serves as on-chip scratch memory and as the self-checking bus target in pipeline simulations. Independent read and write channel FSMs each accept one burst at a time, run concurrently, and support INCR and FIXED bursts with byte strobes.

## Interface
- C_S_AXI_ID_WIDTH, 1, AXI ID width
- C_S_AXI_ADDR_WIDTH, 32, byte address width
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64)
- MEM_DEPTH_WORDS, 1024, memory depth in data words
- S_AXI_ACLK  in  1  clock; the only clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID / S_AXI_ARID  in  ID_WIDTH  write / read burst ID
- S_AXI_AWADDR / S_AXI_ARADDR  in  ADDR_WIDTH  burst start byte address
- S_AXI_AWLEN / S_AXI_ARLEN  in  8  beats minus 1
- S_AXI_AWSIZE / S_AXI_ARSIZE  in  3  beat size
- S_AXI_AWBURST / S_AXI_ARBURST  in  2  burst type
- S_AXI_AWVALID, S_AXI_AWREADY  in, out  1  AW handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WLAST  in  1  final write beat
- S_AXI_WVALID, S_AXI_WREADY  in, out  1  W handshake
- S_AXI_BID  out  ID_WIDTH  echoed AWID
- S_AXI_BRESP / S_AXI_RRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID, S_AXI_BREADY  out, in  1  B handshake
- S_AXI_RID  out  ID_WIDTH  echoed ARID
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RLAST  out  1  final read beat
- S_AXI_RVALID, S_AXI_RREADY  out, in  1  R handshake

## Operation
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored. A beat is in range when index < MEM_DEPTH_WORDS.
- Per beat: INCR advances the index by 1; FIXED holds it. WRAP (10) and reserved (11) burst types are unsupported. No 4 KB boundary check.
- A burst is bad when: burst type is unsupported, or SIZE ≠ log2(DATA_WIDTH/8).
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, index, LEN and burst type.
  - W_DATA: WREADY=1. Each beat writes bytes where WSTRB=1, unless the burst is bad or the beat is out of range (beat is dropped).
  - Beat counter reaches LEN → W_RESP.
  - W_RESP: BVALID=1, BID=latched ID. BRESP=SLVERR if the burst was bad, any beat was out of range, or WLAST mismatched (asserted before beat LEN, or deasserted on beat LEN); otherwise OKAY. Count-based termination is always used.
  - On B handshake → W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch fields.
  - R_DATA: presents mem[index], RID, and RLAST=(beat==LEN).
  - Bad-burst or out-of-range beats return RDATA=0 with RRESP=SLVERR; all others OKAY.
  - After the handshake on the last beat → R_IDLE.
- Read and write run concurrently. Same-word read and write in the same cycle: read returns the old data.
- Memory contents are not reset.

## Timing
- Reset asserted: async clear of AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, RID, BRESP, RRESP and RDATA to 0. Both FSMs go to IDLE and any in-flight burst is aborted.
- First rising edge after reset release: AWREADY=ARREADY=1.
- Write path:
  - WREADY rises 1 cycle after the AW handshake. One beat per cycle while WVALID is held.
  - BVALID rises 1 cycle after the last W handshake and holds until BREADY.
  - AWREADY returns 1 cycle after the B handshake.
- Read path:
  - RVALID rises 1 cycle after the AR handshake (registered RDATA).
  - While RVALID=1 and RREADY=0, RDATA, RID, RRESP and RLAST are held stable.
  - With RREADY held high, one beat per cycle with no bubbles.
  - ARREADY returns 1 cycle after the last R handshake.
- Minimum cycles per burst of N beats, with ready/valid held high:
  - Write: N+3 (AW, N data beats, B, re-arm).
  - Read: N+2.

## Test plan
- Write AWADDR=0x40, AWLEN=3, INCR, data 0x11..0x44, WSTRB=F → BRESP=OKAY, BID=AWID. Then read ARADDR=0x40, ARLEN=3 → 0x11,0x22,0x33,0x44 with RLAST only on beat 3, RRESP=OKAY.
- Word 0 holds 0xAABBCCDD; write 0x11223344 with WSTRB=0101 → read returns 0xAA22CC44.
- Read ARLEN=7 with RREADY toggling 1,0,0,1 → each beat is stable while stalled, 8 beats total, no loss or duplication.
- Write ARADDR/AWADDR=(MEM_DEPTH_WORDS-2)*4, LEN=3 → beats 0-1 stored, beats 2-3 dropped, BRESP=SLVERR. Same-range read → beats 2-3 return RDATA=0 with SLVERR.
- AWBURST=WRAP, and separately WLAST high on beat 1 of LEN=3 → no memory change for the WRAP burst; BRESP=SLVERR for both; FSM accepts the next AW.
- Reset asserted mid-read (beat 2 of 8) → RVALID=0 immediately without waiting for a clock. After release, ARREADY=1 on the first edge and a new burst completes normally.
